// File: rtl/hssi_ch_rr_arb.sv
// rtl/hssi_ch_rr_arb.sv - packet-locked round-robin arbiter merging HSSI channel streams
module hssi_ch_rr_arb #(
  parameter int NUM_CH      = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int CH_W        = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             ch_enable,
  input  logic [NUM_CH-1:0]             s_valid,
  input  logic [NUM_CH*TDATA_WIDTH-1:0] s_data,
  input  logic [NUM_CH-1:0]             s_last,
  output logic [NUM_CH-1:0]             s_ready,
  input  logic                          m_ready,
  output logic                          m_valid,
  output logic [TDATA_WIDTH-1:0]        m_data,
  output logic                          m_last,
  output logic [CH_W-1:0]               m_chan,
  output logic [31:0]                   pkt_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CH_W-1:0]        grant;
  logic [CH_W-1:0]        grant_nxt;
  logic [CH_W-1:0]        last_grant;
  logic [CH_W-1:0]        rr_pick;
  logic                   any_elig;
  logic [NUM_CH-1:0]      elig;
  logic [CH_W:0]          rr_sum;
  logic [CH_W-1:0]        rr_idx;
  logic                   sel_valid;
  logic                   sel_last;
  logic                   out_free;
  logic                   accept;
  logic                   pkt_done;
  logic [TDATA_WIDTH-1:0] s_data_arr [NUM_CH];

  // Unpack the flat data bus so the granted lane can be selected by index.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign s_data_arr[i] = s_data[i*TDATA_WIDTH +: TDATA_WIDTH];
  end

  assign elig      = s_valid & ch_enable;
  assign sel_valid = s_valid[grant];
  assign sel_last  = s_last[grant];
  // The output register can take a beat when empty or draining this cycle.
  assign out_free  = !m_valid || m_ready;

  // Round-robin search: first eligible lane starting just above the last packet's owner.
  always_comb begin
    rr_pick  = '0;
    any_elig = 1'b0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      rr_sum = {1'b0, last_grant} + (CH_W+1)'(i);
      if (rr_sum >= (CH_W+1)'(NUM_CH)) begin
        rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
      end
      rr_idx = rr_sum[CH_W-1:0];
      if (!any_elig && elig[rr_idx]) begin
        rr_pick  = rr_idx;
        any_elig = 1'b1;
      end
    end
  end

  // Next-state and handshake decode; grant only changes while arbitrating in IDLE.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    s_ready   = '0;
    accept    = 1'b0;
    pkt_done  = 1'b0;
    case (state)
      IDLE: begin
        if (any_elig) begin
          grant_nxt = rr_pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        s_ready[grant] = out_free;
        accept         = sel_valid && out_free;
        if (accept && sel_last) begin
          pkt_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // Arbiter state, grant, round-robin pointer and packet counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      pkt_cnt    <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (pkt_done) begin
        last_grant <= grant;
        pkt_cnt    <= pkt_cnt + 32'd1;
      end
    end
  end

  // Single output register: load on accept, empty when drained with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_chan  <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= s_data_arr[grant];
      m_last  <= sel_last;
      m_chan  <= grant;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hssi_ch_rr_arb.sv
// tb/tb_hssi_ch_rr_arb.sv - scoreboard bench for hssi_ch_rr_arb
module tb_hssi_ch_rr_arb;
  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int CH_W   = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_CH-1:0]    ch_enable = '1;
  logic [NUM_CH-1:0]    s_valid = '0;
  logic [NUM_CH*DW-1:0] s_data = '0;
  logic [NUM_CH-1:0]    s_last = '0;
  logic [NUM_CH-1:0]    s_ready;
  logic                 m_ready = 1'b1;
  logic                 m_valid;
  logic [DW-1:0]        m_data;
  logic                 m_last;
  logic [CH_W-1:0]      m_chan;
  logic [31:0]          pkt_cnt;

  hssi_ch_rr_arb #(.NUM_CH(NUM_CH), .TDATA_WIDTH(DW), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .ch_enable(ch_enable), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .m_ready(m_ready), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_chan(m_chan), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [34:0] exp_q [$];
  bit          trace_on = 1'b0;
  logic        tr_valid [$];
  logic [1:0]  tr_chan [$];
  logic        tr_last [$];
  logic [31:0] tr_cnt [$];
  int rem [NUM_CH];
  int plen [NUM_CH];
  int beat [NUM_CH];
  int pkt [NUM_CH];

  function automatic logic [31:0] mk(int c, int p, int b);
    return {8'(c), 8'(p), 8'(b), 8'hA5};
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push_pkt(int c, int p, int len);
    for (int b = 0; b < len; b++) begin
      exp_q.push_back({2'(c), logic'(b == len - 1), mk(c, p, b)});
    end
  endtask

  task automatic load(int c, int n, int len);
    rem[c]  = n;
    plen[c] = len;
    beat[c] = 0;
  endtask

  task automatic drive_srcs();
    for (int c = 0; c < NUM_CH; c++) begin
      s_valid[c] = (rem[c] > 0);
      s_last[c]  = (beat[c] == plen[c] - 1);
      s_data[c*DW +: DW] = mk(c, pkt[c], beat[c]);
    end
  endtask

  task automatic step();
    logic [NUM_CH-1:0] f;
    @(negedge clk);
    f = s_valid & s_ready;
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (f[c] && !rst) begin
        beat[c]++;
        if (beat[c] == plen[c]) begin
          beat[c] = 0;
          pkt[c]++;
          rem[c]--;
        end
      end
    end
    drive_srcs();
  endtask

  task automatic run_until_empty(int max);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) step();
  endtask

  // Monitor: pop the scoreboard on every output handshake and record the cycle trace.
  always @(negedge clk) begin
    logic [34:0] e;
    if (trace_on) begin
      tr_valid.push_back(m_valid);
      tr_chan.push_back(m_chan);
      tr_last.push_back(m_last);
      tr_cnt.push_back(pkt_cnt);
    end
    if (!rst && m_valid && m_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat got=%0h exp=none", {m_chan, m_last, m_data});
      end else begin
        e = exp_q.pop_front();
        if ({m_chan, m_last, m_data} !== e) begin
          n_fail++;
          $display("FAIL beat got=%0h exp=%0h", {m_chan, m_last, m_data}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p1, p2, pc, n, k;
    logic ev;
    for (int c = 0; c < NUM_CH; c++) begin
      rem[c] = 0; plen[c] = 1; beat[c] = 0; pkt[c] = 0;
    end

    // Reset state with all four channels already offering 3-beat packets.
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NUM_CH; c++)
        push_pkt(c, p, 3);
    for (int c = 0; c < NUM_CH; c++) load(c, 2, 3);
    drive_srcs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_chan", 64'(m_chan), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);

    // A: strict rotation, one gap cycle between packets.
    rst = 1'b0;
    trace_on = 1'b1;
    repeat (36) step();
    trace_on = 1'b0;
    for (int i = 0; i < 36; i++) begin
      k  = i - 2;
      ev = (i >= 2) && (i < 34) && ((k % 4) != 3);
      chk($sformatf("A_valid[%0d]", i), 64'(tr_valid[i]), 64'(ev));
      if (ev) begin
        chk($sformatf("A_chan[%0d]", i), 64'(tr_chan[i]), 64'((k / 4) % 4));
        chk($sformatf("A_last[%0d]", i), 64'(tr_last[i]), 64'((k % 4) == 2));
      end
    end
    chk("A_cnt_before_4th", 64'(tr_cnt[15]), 64'd3);
    chk("A_cnt_at_4th", 64'(tr_cnt[16]), 64'd4);
    chk("A_cnt_end", 64'(pkt_cnt), 64'd8);
    chk("A_q_empty", 64'(exp_q.size()), 64'd0);

    // B: only channel 2, single-beat packets.
    tr_valid.delete(); tr_chan.delete(); tr_last.delete(); tr_cnt.delete();
    for (int j = 0; j < 3; j++) push_pkt(2, pkt[2] + j, 1);
    load(2, 3, 1);
    drive_srcs();
    trace_on = 1'b1;
    repeat (8) step();
    trace_on = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ev = (i == 2) || (i == 4) || (i == 6);
      chk($sformatf("B_valid[%0d]", i), 64'(tr_valid[i]), 64'(ev));
      if (ev) chk($sformatf("B_chan[%0d]", i), 64'(tr_chan[i]), 64'd2);
    end
    run_until_empty(20);

    // C: back-pressure freezes the output register mid-packet.
    pc = pkt[0];
    push_pkt(0, pc, 4);
    load(0, 1, 4);
    drive_srcs();
    repeat (3) step();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("C_hold_valid", 64'(m_valid), 64'd1);
      chk("C_hold_data", 64'(m_data), 64'(mk(0, pc, 1)));
      chk("C_hold_last", 64'(m_last), 64'd0);
      chk("C_hold_chan", 64'(m_chan), 64'd0);
      chk("C_hold_s_ready", 64'(s_ready), 64'd0);
      step();
    end
    m_ready = 1'b1;
    run_until_empty(40);

    // D: disabling channel 1 mid-packet lets it finish, then skips it until re-enabled.
    p1 = pkt[1];
    p2 = pkt[2];
    push_pkt(1, p1, 3);
    push_pkt(2, p2, 3);
    push_pkt(2, p2 + 1, 3);
    push_pkt(1, p1 + 1, 3);
    load(1, 2, 3);
    load(2, 2, 3);
    drive_srcs();
    repeat (2) step();
    ch_enable = 4'b1101;
    repeat (30) step();
    chk("D_q_left", 64'(exp_q.size()), 64'd3);
    chk("D_idle_valid", 64'(m_valid), 64'd0);
    chk("D_ch1_ready", 64'(s_ready), 64'd0);
    ch_enable = 4'b1111;
    run_until_empty(40);

    // E: reset during beat 2 of a 4-beat packet discards it; channel 0 wins after release.
    p0 = pkt[0];
    exp_q.push_back({2'd0, 1'b0, mk(0, p0, 0)});
    load(0, 1, 4);
    drive_srcs();
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("E_rst_m_valid", 64'(m_valid), 64'd0);
    chk("E_rst_s_ready", 64'(s_ready), 64'd0);
    chk("E_rst_m_data", 64'(m_data), 64'd0);
    chk("E_rst_m_last", 64'(m_last), 64'd0);
    rem[0] = 0; beat[0] = 0; pkt[0]++;
    drive_srcs();
    repeat (2) step();
    chk("E_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("E_q_empty", 64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    push_pkt(0, pkt[0], 2);
    push_pkt(3, pkt[3], 2);
    load(3, 1, 2);
    load(0, 1, 2);
    drive_srcs();
    run_until_empty(40);

    // F: packet counter wraps from all-ones.
    force dut.pkt_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt;
    push_pkt(2, pkt[2], 1);
    push_pkt(2, pkt[2] + 1, 1);
    load(2, 2, 1);
    drive_srcs();
    n = 0;
    while (pkt_cnt == 32'hFFFF_FFFF && n < 20) begin
      step();
      n++;
    end
    chk("F_wrap0", 64'(pkt_cnt), 64'd0);
    n = 0;
    while (pkt_cnt == 32'd0 && n < 20) begin
      step();
      n++;
    end
    chk("F_wrap1", 64'(pkt_cnt), 64'd1);
    run_until_empty(20);

    chk("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
